pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Inputs: decoded control bits and register fields from the ID and EX stages, plus the MEM-stage data-memory handshake.
- Outputs: per-stage pipeline-register enables and bubble/flush strobes.
- Owns load-use stalls, taken-branch/jump flushes, and freezing the whole pipeline while data memory is busy, with a timeout trap.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles in MEM_WAIT before trapping; legal range 2..255.
- CNT_W, 32: width of the stall-cycle counter (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_jump  in  1  ID instruction is a jump
- ex_rt  in  5  destination rt of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM stage has an active load/store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register enable
- if_id_en  out  1  IF/ID enable
- id_ex_en  out  1  ID/EX enable
- ex_mem_en  out  1  EX/MEM enable
- mem_wb_en  out  1  MEM/WB enable
- if_id_flush  out  1  load NOP into IF/ID at next edge
- id_ex_flush  out  1  load bubble (all controls 0) into ID/EX at next edge
- mem_timeout  out  1  sticky trap flag
- stall_cycles  out  CNT_W  stall counter (only with PERF_CNT_EN)

Behaviour:
- States: RUN, MEM_WAIT, TRAP. State, wait timer and mem_timeout are registered; all enable and flush outputs are combinational from state and inputs.
- Reset (async, any time, including mid-MEM_WAIT):
  - state=RUN, timer=0, mem_timeout=0, stall_cycles=0.
  - While reset is high, all *_en=0 and both flushes=1.
- load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- RUN, priority top-down (first match wins):
  1. mem_req && !mem_ready: all *_en=0, flushes=0. Next state MEM_WAIT, timer<=1.
  2. ex_branch_taken: all *_en=1, if_id_flush=1, id_ex_flush=1. Load-use and jump are ignored because the flushed instructions are wrong-path.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en/ex_mem_en/mem_wb_en=1. Exactly 1 bubble results, since the load has moved to MEM next cycle.
  4. id_jump: all *_en=1, if_id_flush=1, id_ex_flush=0.
  5. Otherwise: all *_en=1, flushes=0.
- MEM_WAIT:
  - mem_ready=1: outputs are evaluated exactly as RUN items 2-5 (mem request treated as complete). Next state RUN, timer<=0.
  - mem_ready=0 and timer==MEM_TIMEOUT-1: all *_en=0. Next state TRAP, mem_timeout<=1.
  - Otherwise: all *_en=0, flushes=0, timer<=timer+1.
  - Branch, jump and load-use inputs held frozen in EX/ID are acted on at the release cycle, never during the wait.
- TRAP: all *_en=0, flushes=0, mem_timeout=1. Exits only by reset.
- Zero-latency handshake: mem_req && mem_ready in the same cycle in RUN means no stall.
- Register $0 never causes a load-use stall.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - stall_cycles port exists.
  - Increments by 1 on each clock where pc_en==0 while not in reset.
  - Saturates at all-ones; never wraps.
  - Reset to 0.
- Undefined: the stall_cycles port and its counter are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; with ex_rt=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 with load_use true -> if_id_flush=1, id_ex_flush=1, pc_en=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, all 1 on the 4th cycle, state RUN afterwards; with PERF_CNT_EN, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready never asserted -> mem_timeout rises after 4 frozen cycles and stays high with enables 0 until reset.
- Async reset mid-MEM_WAIT: assert reset between clock edges -> outputs go to reset values immediately, state RUN, mem_timeout=0; normal flow after deassert.
- Jump: id_jump=1, no other hazard -> if_id_flush=1, id_ex_flush=0, all enables 1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage MIPS pipeline.
// Resolves load-use stalls, taken-branch and jump flushes, and freezes the
// whole pipeline while data memory is busy, trapping after MEM_TIMEOUT
// consecutive frozen cycles.
// Optional macro PERF_CNT_EN adds a saturating stall-cycle counter
// (stall_cycles port, width CNT_W).
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_timeout
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

  // Timer value at which a still-pending access gives up and traps.
  localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic       load_use;
  logic [4:0] run_en;        // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic       run_if_flush;
  logic       run_id_flush;
  logic [4:0] en;
  logic       if_flush;
  logic       id_flush;

  // Hazard resolution for a cycle in which memory is not holding the pipe.
  always_comb begin
    load_use     = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    run_en       = 5'b11111;
    run_if_flush = 1'b0;
    run_id_flush = 1'b0;
    if (ex_branch_taken) begin
      // Everything younger than the branch is wrong-path; squash it all.
      run_if_flush = 1'b1;
      run_id_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID one cycle, inject a single bubble into EX.
      run_en       = 5'b00111;
      run_id_flush = 1'b1;
    end else if (id_jump) begin
      run_if_flush = 1'b1;
    end
  end

  // Next-state and output logic of the memory-wait sequencer.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    mem_timeout_d = mem_timeout_q;
    en            = 5'b00000;
    if_flush      = 1'b0;
    id_flush      = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
          timer_d = 8'd1;
        end else begin
          en       = run_en;
          if_flush = run_if_flush;
          id_flush = run_id_flush;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          // Release cycle: hazards frozen during the wait are handled now.
          en       = run_en;
          if_flush = run_if_flush;
          id_flush = run_id_flush;
          state_d  = RUN;
          timer_d  = 8'd0;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = TRAP;
          mem_timeout_d = 1'b1;
        end else begin
          timer_d = 8'(timer_q + 8'd1);
        end
      end
      TRAP: begin
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        timer_d = 8'd0;
      end
    endcase
    if (reset) begin
      en       = 5'b00000;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end
  end

  // State, wait timer and sticky trap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      timer_q       <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_en       = en[4];
  assign if_id_en    = en[3];
  assign id_ex_en    = en[2];
  assign ex_mem_en   = en[1];
  assign mem_wb_en   = en[0];
  assign if_id_flush = if_flush;
  assign id_ex_flush = id_flush;
  assign mem_timeout = mem_timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Count cycles with the PC held, saturating at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!en[4] && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_timeout;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  bit          m_waiting;   // a memory access is outstanding
  int          m_frozen;    // consecutive frozen cycles so far
  bit          m_trap;
  int unsigned m_stall;
  int          trap_age;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout(mem_timeout)
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs_vec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
  endfunction

  function automatic bit model_frozen();
    return m_trap || (!mem_ready && (m_waiting || mem_req));
  endfunction

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb,if_flush,id_flush} from the rules.
  function automatic logic [6:0] expect_outs();
    bit hazard_reg;
    if (reset) return 7'b00000_11;
    if (model_frozen()) return 7'b00000_00;
    hazard_reg = (ex_rt != 0) && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (ex_branch_taken)             return 7'b11111_11;
    if (ex_mem_read && hazard_reg)   return 7'b00111_01;
    if (id_jump)                     return 7'b11111_10;
    return 7'b11111_00;
  endfunction

  task automatic model_clear();
    m_waiting = 0; m_frozen = 0; m_trap = 0; m_stall = 0; trap_age = 0;
  endtask

  task automatic model_step(input logic [6:0] exp);
    if (m_trap) begin
      trap_age++;
    end else if (model_frozen()) begin
      m_waiting = 1;
      m_frozen++;
      if (m_frozen == MEM_TIMEOUT) m_trap = 1;
    end else begin
      m_waiting = 0;
      m_frozen  = 0;
    end
    if (!exp[6] && m_stall != 32'hFFFF_FFFF) m_stall++;
  endtask

  task automatic set_idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0; ex_rt = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // One clock of stimulus: drive after the falling edge, check, advance model.
  task automatic cycle(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic jmp, input logic [4:0] xrt,
                       input logic mrd, input logic br, input logic req, input logic rdy);
    logic [6:0] exp;
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_jump = jmp; ex_rt = xrt;
    ex_mem_read = mrd; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    #1;
    exp = expect_outs();
    $display("cyc %0t %s rs=%0d rt=%0d urt=%0b j=%0b xrt=%0d ld=%0b br=%0b req=%0b rdy=%0b outs=%b exp=%b to=%0b",
             $time, tag, rs, rt, urt, jmp, xrt, mrd, br, req, rdy, outs_vec(), exp, mem_timeout);
    check_val({tag, "_outs"}, 32'(outs_vec()), 32'(exp));
    check_val({tag, "_to"}, 32'(mem_timeout), 32'(m_trap));
`ifdef PERF_CNT_EN
    check_val({tag, "_stall"}, stall_cycles, m_stall);
`endif
    model_step(exp);
  endtask

  // Assert reset between clock edges and check the reset-time outputs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val({tag, "_rst_outs"}, 32'(outs_vec()), 32'h03);
    check_val({tag, "_rst_to"}, 32'(mem_timeout), 32'h0);
`ifdef PERF_CNT_EN
    check_val({tag, "_rst_stall"}, stall_cycles, 32'h0);
`endif
    model_clear();
    set_idle();
    @(posedge clk);
    #1;
    check_val({tag, "_rst_hold"}, 32'(outs_vec()), 32'h03);
    @(negedge clk);
    reset = 1'b0;
    $display("reset %0t %s done", $time, tag);
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    model_clear();
    #2;
    check_val("por_outs", 32'(outs_vec()), 32'h03);
    check_val("por_to", 32'(mem_timeout), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Load-use on rs, then released; $0 never stalls.
    cycle("lu",      5'd8, 5'd1, 0, 0, 5'd8, 1, 0, 0, 0);
    check_val("lu_pc", 32'(pc_en), 32'h0);
    cycle("lu_next", 5'd9, 5'd1, 0, 0, 5'd8, 0, 0, 0, 0);
    check_val("lu_next_pc", 32'(pc_en), 32'h1);
    cycle("lu_rt",   5'd3, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0);
    cycle("lu_rt_nouse", 5'd3, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0);
    cycle("lu_r0",   5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
    check_val("lu_r0_pc", 32'(pc_en), 32'h1);

    // Branch beats load-use; jump alone.
    cycle("br_lu",   5'd8, 5'd1, 0, 1, 5'd8, 1, 1, 0, 0);
    check_val("br_lu_flush", 32'({if_id_flush, id_ex_flush, pc_en}), 32'h7);
    cycle("jump",    5'd1, 5'd2, 0, 1, 5'd5, 0, 0, 0, 0);
    cycle("zero_lat", 5'd1, 5'd2, 0, 0, 5'd5, 0, 0, 1, 1);

    // Three-cycle memory wait with a jump frozen in ID.
    do_reset("mw");
    cycle("mw0", 5'd1, 5'd2, 0, 1, 5'd5, 0, 0, 1, 0);
    cycle("mw1", 5'd1, 5'd2, 0, 1, 5'd5, 0, 0, 1, 0);
    cycle("mw2", 5'd1, 5'd2, 0, 1, 5'd5, 0, 0, 1, 0);
    cycle("mw_rel", 5'd1, 5'd2, 0, 1, 5'd5, 0, 0, 1, 1);
    check_val("mw_rel_jump", 32'(outs_vec()), 32'h7E);
    cycle("mw_after", 5'd1, 5'd2, 0, 0, 5'd5, 0, 0, 0, 0);
`ifdef PERF_CNT_EN
    check_val("mw_stall3", stall_cycles, 32'd3);
`endif

    // Timeout: ready never comes; trap is sticky until reset.
    for (int i = 0; i < MEM_TIMEOUT; i++) cycle("to_wait", 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    cycle("to_trap", 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 1, 1);
    check_val("to_flag", 32'(mem_timeout), 32'h1);
    cycle("to_stay", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);

    // Async reset while a wait is in progress.
    do_reset("to_clr");
    cycle("arw0", 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    cycle("arw1", 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
    do_reset("arw");
    cycle("arw_norm", 5'd4, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0);
    check_val("arw_norm_en", 32'(outs_vec()), 32'h7C);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      if ((m_trap && trap_age >= 3) || $urandom_range(0, 299) == 0) begin
        do_reset("rnd");
      end else begin
        cycle("rnd", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 9) < 6));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
